fnd_time_display: RTL and testbench
===================================

Name: fnd_time_display

Overview:
- Display-side consumer for the watch, cook-timer and stop-watch blocks; takes their two 8-bit binary time fields (min/sec or sec/csec) and drives a 4-digit multiplexed common-anode 7-segment display.
- Runs a sequential binary-to-BCD converter, a digit scan ring, and a blink generator for set mode and alarm flashing.
- Sits between the timer blocks and the board's FND pins.

Parameters:
- SCAN_DIV, 100_000: clk cycles per digit slot (1 ms at 100 MHz).
- BLINK_DIV, 50_000_000: clk cycles per blink phase toggle (0.5 s).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_p  in  1  asynchronous reset, active-high.
- hi_val  in  8  binary value for the left digit pair (digits 3,2); valid range 0..99.
- lo_val  in  8  binary value for the right digit pair (digits 1,0); valid range 0..99.
- blink_en  in  2  bit1 blinks the hi pair, bit0 blinks the lo pair.
- alarm_in  in  1  flash all four digits while high.
- dp_mask  in  4  decimal point enable per digit, bit n is digit n.
- seg_n  out  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}.
- com_n  out  4  active-low digit enables; bit0 is the rightmost digit.

Behaviour:
- Reset is clk and reset_p, asynchronous, active-high. While asserted:
  - seg_n=8'hFF, com_n=4'b1111.
  - Scan counter=0, digit index=0, blink phase=1 (visible).
  - Display digit registers=0, converter in LOAD.
- Converter FSM runs continuously and handles both bytes in parallel (double-dabble, add-3-if-≥5 before each shift):
  - LOAD (1 cycle): snapshots hi_val and lo_val.
  - SHIFT (8 cycles): one shift per cycle.
  - COMMIT (1 cycle): writes all four BCD digit registers atomically, then returns to LOAD.
  - Period is 10 cycles. An input change is reflected in the digit registers within 20 cycles.
  - Inputs are sampled only in LOAD; changes during SHIFT are ignored until the next LOAD.
- Out-of-range values: if a snapshot value is >99, both digits of that pair commit the dash code (segment g only, seg_n[6:0]=7'b0111111). The other pair is unaffected.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - The first wrap after reset drives com_n=4'b1110.
  - Exactly one com_n bit is low after that point.
  - com_n and seg_n are registered and change in the same cycle.
- Segment decode:
  - Codes are standard hex-style for BCD 0..9 and dash.
  - seg_n[7] = ~dp_mask[idx], i.e. the dp follows dp_mask for the active digit.
- Blink:
  - The blink counter counts 0..BLINK_DIV-1. On wrap, the phase toggles.
  - A digit is blanked (seg_n=8'hFF, com_n still scans) when phase=0 and either alarm_in=1 or the blink_en bit of its pair is 1.
  - The blink counter runs freely and is not reset by blink_en or alarm_in edges.
- Priority: alarm_in overrides blink_en. dp_mask is blanked together with its digit.
- Reset mid-operation: all state returns to reset values immediately. There is no partial commit.

Decomposition:
- Package fnd_pkg holds:
  - SEG_DIGIT[0:9] 7-bit active-low patterns, SEG_DASH, SEG_BLANK=8'hFF.
  - Digit-index typedef (2-bit).
  - Converter state enum {LOAD, SHIFT, COMMIT}.
- Sub-module bin2bcd_seq: 8-bit sequential double-dabble with start/done, instantiated twice (hi, lo) and sharing the top FSM's strobe.
- The scan ring, blink generator and decode stay in the top module.

Test Plan:
All cases use SCAN_DIV=4 and BLINK_DIV=32.
1. Reset release, hi_val=12, lo_val=34 → com_n=1111 and seg_n=FF until the first scan wrap, then the sequence 1110/1101/1011/0111 every 4 cycles. Segments show 4,3,2,1 (seg_n 8'h99, 8'hB0, 8'hA4, 8'hF9).
2. lo_val changes 34→59 mid-SHIFT → digits 1,0 show 3,4 until the next COMMIT, then 5,9 within 20 cycles. hi_val digits never glitch.
3. hi_val=150, lo_val=7 → digits 3,2 show dash (seg_n 8'hBF) and digits 1,0 show 0,7.
4. blink_en=2'b10 → digits 3,2 are seg_n=FF for 32 cycles and visible for 32 cycles, alternating. Digits 1,0 stay steady. com_n scan is unchanged.
5. alarm_in=1 with blink_en=00 → all digits blank during phase 0. Setting dp_mask=4'b0100 gives seg_n[7]=0 only on digit 2 while visible.
6. Assert reset_p during SHIFT with scan on digit 2 → next cycle com_n=1111, seg_n=FF. After release, the display restarts from digit 0 with freshly converted values.

Source files
------------

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared types and constants for the 4-digit FND time display.
//   SEG_DIGIT  active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
//   SEG_DASH   pattern for an out-of-range pair (segment g only)
//   SEG_BLANK  full 8-bit blank (dp + segments off)
//   CODE_DASH  4-bit digit-register code that decodes to SEG_DASH
//   digit_idx_t, conv_state_t, seg_of() decode helper
package fnd_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] CODE_DASH = 4'hA;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Digit-register code to 7-segment pattern; any non-BCD code shows a dash.
  function automatic logic [6:0] seg_of(input logic [3:0] code);
    logic [6:0] pat;
    if (code <= 4'd9) begin
      pat = SEG_DIGIT[code];
    end else begin
      pat = SEG_DASH;
    end
    return pat;
  endfunction

endpackage

// File: rtl/fnd_time_display_bin2bcd_seq.sv
// bin2bcd_seq: 8-bit sequential double-dabble converter (two BCD digits).
//   clk, reset_p  clock, async active-high reset
//   start         snapshot value and clear the BCD accumulator
//   shift         perform one add-3/shift step (ignored once 8 steps are done)
//   value         binary input, sampled only on start
//   tens, ones    BCD result after 8 steps (valid only when over=0)
//   over          snapshot was >99; the caller shows a dash instead
//   done          all 8 steps completed since the last start
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_p,
  input  logic       start,
  input  logic       shift,
  input  logic [7:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       over,
  output logic       done
);

  logic [7:0]  bin_r;
  logic [7:0]  bcd_r;
  logic [3:0]  cnt_r;
  logic        over_r;
  logic [7:0]  bcd_adj_s;
  logic [15:0] shifted_s;

  // Add 3 to every BCD nibble that is 5 or more, then shift the pair left.
  // Only two nibbles are kept: values >99 are flagged by over and never shown.
  always_comb begin
    bcd_adj_s = bcd_r;
    if (bcd_r[3:0] >= 4'd5) begin
      bcd_adj_s[3:0] = bcd_r[3:0] + 4'd3;
    end else begin
      bcd_adj_s[3:0] = bcd_r[3:0];
    end
    if (bcd_r[7:4] >= 4'd5) begin
      bcd_adj_s[7:4] = bcd_r[7:4] + 4'd3;
    end else begin
      bcd_adj_s[7:4] = bcd_r[7:4];
    end
    shifted_s = {bcd_adj_s, bin_r} << 1;
  end

  // Snapshot on start, one double-dabble step per shift strobe.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      bin_r  <= 8'd0;
      bcd_r  <= 8'd0;
      cnt_r  <= 4'd0;
      over_r <= 1'b0;
    end else if (start) begin
      bin_r  <= value;
      bcd_r  <= 8'd0;
      cnt_r  <= 4'd0;
      over_r <= (value > 8'd99);
    end else if (shift && (cnt_r != 4'd8)) begin
      {bcd_r, bin_r} <= shifted_s;
      cnt_r          <= cnt_r + 4'd1;
    end
  end

  assign tens = bcd_r[7:4];
  assign ones = bcd_r[3:0];
  assign over = over_r;
  assign done = (cnt_r == 4'd8);

endmodule

// File: rtl/fnd_time_display.sv
// fnd_time_display: 4-digit multiplexed common-anode 7-segment driver.
//   clk, reset_p  100 MHz clock, async active-high reset
//   hi_val        binary 0..99 for digits 3,2 (>99 shows dashes)
//   lo_val        binary 0..99 for digits 1,0 (>99 shows dashes)
//   blink_en      bit1 blinks the hi pair, bit0 the lo pair
//   alarm_in      flash all digits while high (overrides blink_en)
//   dp_mask       decimal point enable per digit
//   seg_n         active-low {dp,g,f,e,d,c,b,a}, registered
//   com_n         active-low digit enables (bit0 = rightmost), registered
module fnd_time_display
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] hi_val,
  input  logic [7:0] lo_val,
  input  logic [1:0] blink_en,
  input  logic       alarm_in,
  input  logic [3:0] dp_mask,
  output logic [7:0] seg_n,
  output logic [3:0] com_n
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  conv_state_t        state_r;
  logic [2:0]         shift_cnt_r;
  logic [3:0]         dig_r [0:3];
  logic               start_s, shift_s;
  logic [3:0]         hi_tens_s, hi_ones_s, lo_tens_s, lo_ones_s;
  logic               hi_over_s, lo_over_s, hi_done_s, lo_done_s;

  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               phase_r;
  logic               active_r;
  digit_idx_t         idx_r;

  logic               scan_wrap_s, active_nxt_s, blank_s, pair_blink_s;
  digit_idx_t         idx_nxt_s;
  logic [7:0]         seg_nxt_s;
  logic [3:0]         com_nxt_s;

  assign start_s = (state_r == LOAD);
  assign shift_s = (state_r == SHIFT);

  bin2bcd_seq u_hi (
    .clk(clk), .reset_p(reset_p), .start(start_s), .shift(shift_s),
    .value(hi_val), .tens(hi_tens_s), .ones(hi_ones_s),
    .over(hi_over_s), .done(hi_done_s)
  );

  bin2bcd_seq u_lo (
    .clk(clk), .reset_p(reset_p), .start(start_s), .shift(shift_s),
    .value(lo_val), .tens(lo_tens_s), .ones(lo_ones_s),
    .over(lo_over_s), .done(lo_done_s)
  );

  // Converter sequencer: LOAD(1) -> SHIFT(8) -> COMMIT(1), 10-cycle period.
  // All four digit registers are written together in COMMIT only.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_r     <= LOAD;
      shift_cnt_r <= 3'd0;
      for (int i = 0; i < 4; i++) dig_r[i] <= 4'd0;
    end else begin
      case (state_r)
        LOAD: begin
          shift_cnt_r <= 3'd0;
          state_r     <= SHIFT;
        end
        SHIFT: begin
          shift_cnt_r <= shift_cnt_r + 3'd1;
          if (shift_cnt_r == 3'd7) state_r <= COMMIT;
        end
        COMMIT: begin
          if (hi_done_s && lo_done_s) begin
            dig_r[3] <= hi_over_s ? CODE_DASH : hi_tens_s;
            dig_r[2] <= hi_over_s ? CODE_DASH : hi_ones_s;
            dig_r[1] <= lo_over_s ? CODE_DASH : lo_tens_s;
            dig_r[0] <= lo_over_s ? CODE_DASH : lo_ones_s;
          end
          state_r <= LOAD;
        end
        default: state_r <= LOAD;
      endcase
    end
  end

  // Next scan position and the segment/common values it should drive.
  // The first wrap after reset lights digit 0; later wraps advance the index.
  always_comb begin
    scan_wrap_s  = (scan_cnt_r == SCAN_W'(SCAN_DIV - 1));
    active_nxt_s = active_r | scan_wrap_s;
    if (scan_wrap_s && active_r) begin
      idx_nxt_s = idx_r + 2'd1;
    end else begin
      idx_nxt_s = idx_r;
    end
    pair_blink_s = idx_nxt_s[1] ? blink_en[1] : blink_en[0];
    blank_s      = !phase_r && (alarm_in || pair_blink_s);
    if (!active_nxt_s) begin
      seg_nxt_s = SEG_BLANK;
      com_nxt_s = 4'b1111;
    end else begin
      com_nxt_s = ~(4'b0001 << idx_nxt_s);
      if (blank_s) begin
        seg_nxt_s = SEG_BLANK;
      end else begin
        seg_nxt_s = {~dp_mask[idx_nxt_s], seg_of(dig_r[idx_nxt_s])};
      end
    end
  end

  // Scan ring, free-running blink generator and registered pin outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      scan_cnt_r  <= '0;
      blink_cnt_r <= '0;
      phase_r     <= 1'b1;
      active_r    <= 1'b0;
      idx_r       <= 2'd0;
      seg_n       <= SEG_BLANK;
      com_n       <= 4'b1111;
    end else begin
      if (scan_wrap_s) begin
        scan_cnt_r <= '0;
      end else begin
        scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      end
      if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_r <= '0;
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end
      active_r <= active_nxt_s;
      idx_r    <= idx_nxt_s;
      seg_n    <= seg_nxt_s;
      com_n    <= com_nxt_s;
    end
  end

endmodule

// File: tb/tb_fnd_time_display.sv
// Directed bench for fnd_time_display with SCAN_DIV=4, BLINK_DIV=32.
module tb_fnd_time_display;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [7:0] hi_val, lo_val;
  logic [1:0] blink_en;
  logic       alarm_in;
  logic [3:0] dp_mask;
  logic [7:0] seg_n;
  logic [3:0] com_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]      hi;
    logic [7:0]      lo;
    logic [3:0]      dp;
    logic [3:0][7:0] exp;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t       vecs [8];
  logic [6:0] pat  [4];     // visible patterns of 12/34, indexed by digit
  logic [3:0] one4 = 4'b0001;

  fnd_time_display #(.SCAN_DIV(4), .BLINK_DIV(32)) dut (
    .clk(clk), .reset_p(reset_p), .hi_val(hi_val), .lo_val(lo_val),
    .blink_en(blink_en), .alarm_in(alarm_in), .dp_mask(dp_mask),
    .seg_n(seg_n), .com_n(com_n)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) until digit d is being scanned, return its segments.
  task automatic grab(input int d, output logic [7:0] s);
    logic [3:0] tgt;
    bit found;
    tgt = ~(one4 << d);
    found = 1'b0;
    s = 8'hxx;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (com_n == tgt) begin
        found = 1'b1;
        s = seg_n;
      end
    end
    if (!found) check4("grab_timeout", com_n, tgt);
  endtask

  task automatic do_reset(input logic [7:0] h, input logic [7:0] l);
    reset_p = 1'b1;
    hi_val  = h;
    lo_val  = l;
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
  endtask

  // Blink/alarm run from reset with 12/34 on display, 140 cycles.
  task automatic run_blink(input logic [1:0] be, input logic al, input logic [3:0] dp);
    int d;
    bit blanked;
    logic [7:0] exp;
    blink_en = be;
    alarm_in = al;
    dp_mask  = dp;
    do_reset(8'd12, 8'd34);
    for (int k = 1; k <= 140; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k >= 4) begin
        d = ((k - 4) / 4) % 4;
        check4("blink_scan", com_n, ~(one4 << d));
        if (k >= 12 && (k % 32) > 1) begin
          blanked = ((((k - 1) / 32) % 2) == 1) && (al || (d >= 2 ? be[1] : be[0]));
          exp = blanked ? 8'hFF : {~dp[d], pat[d]};
          check8(al ? "alarm_seg" : "blink_seg", seg_n, exp);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] es;
    bit         has;

    pat[0] = 7'h19; pat[1] = 7'h30; pat[2] = 7'h24; pat[3] = 7'h79;
    vecs[0] = '{8'd12,  8'd34,  4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{8'd150, 8'd7,   4'b0000, {8'hBF, 8'hBF, 8'hC0, 8'hF8}};
    vecs[2] = '{8'd99,  8'd0,   4'b0000, {8'h90, 8'h90, 8'hC0, 8'hC0}};
    vecs[3] = '{8'd100, 8'd99,  4'b0000, {8'hBF, 8'hBF, 8'h90, 8'h90}};
    vecs[4] = '{8'd56,  8'd81,  4'b0100, {8'h92, 8'h02, 8'h80, 8'hF9}};
    vecs[5] = '{8'd255, 8'd9,   4'b1001, {8'h3F, 8'hBF, 8'hC0, 8'h10}};
    vecs[6] = '{8'd0,   8'd255, 4'b0000, {8'hC0, 8'hC0, 8'hBF, 8'hBF}};
    vecs[7] = '{8'd70,  8'd42,  4'b0010, {8'hF8, 8'hC0, 8'h19, 8'hA4}};

    blink_en = 2'b00;
    alarm_in = 1'b0;
    dp_mask  = 4'b0000;
    reset_p  = 1'b1;
    hi_val   = 8'd12;
    lo_val   = 8'd34;
    repeat (3) @(negedge clk);
    check8("reset_seg", seg_n, 8'hFF);
    check4("reset_com", com_n, 4'b1111);

    // Reset release, scan order, then lo change 34->59 mid-SHIFT at k=25.
    reset_p = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      @(posedge clk);
      @(negedge clk);
      check4("scan_com", com_n, (k < 4) ? 4'b1111 : ~(one4 << (((k - 4) / 4) % 4)));
      has = 1'b1;
      if (k < 4)                    es = 8'hFF;
      else if (k >= 12 && k <= 15)  es = 8'hA4;
      else if (k >= 16 && k <= 19)  es = 8'hF9;
      else if (k >= 20 && k <= 23)  es = 8'h99;
      else if (k >= 24 && k <= 27)  es = 8'hB0;
      else if (k >= 28 && k <= 31)  es = 8'hA4;
      else if (k >= 32 && k <= 35)  es = 8'hF9;
      else if (k >= 36 && k <= 39)  es = 8'h99;
      else if (k >= 41 && k <= 43)  es = 8'h92;
      else if (k >= 44 && k <= 47)  es = 8'hA4;
      else if (k >= 48 && k <= 51)  es = 8'hF9;
      else if (k >= 52 && k <= 55)  es = 8'h90;
      else begin
        has = 1'b0;
        es  = 8'hFF;
      end
      if (has) check8("scan_seg", seg_n, es);
      if (k == 25) lo_val = 8'd59;
    end

    // Table of value/dp patterns, each given time to convert.
    for (int v = 0; v < 8; v++) begin
      hi_val  = vecs[v].hi;
      lo_val  = vecs[v].lo;
      dp_mask = vecs[v].dp;
      repeat (22) @(negedge clk);
      for (int d = 3; d >= 0; d--) begin
        grab(d, s);
        check8($sformatf("vec%0d_dig%0d", v, d), s, vecs[v].exp[d]);
      end
    end

    run_blink(2'b10, 1'b0, 4'b0000);
    run_blink(2'b00, 1'b1, 4'b0100);

    // Reset mid-SHIFT while digit 2 is scanned; restart with fresh values.
    blink_en = 2'b00;
    alarm_in = 1'b0;
    dp_mask  = 4'b0000;
    do_reset(8'd12, 8'd34);
    repeat (13) @(negedge clk);
    check4("pre_rst_com", com_n, 4'b1011);
    reset_p = 1'b1;
    #1;
    check8("midrst_seg", seg_n, 8'hFF);
    check4("midrst_com", com_n, 4'b1111);
    @(negedge clk);
    check4("midrst_com2", com_n, 4'b1111);
    hi_val  = 8'd70;
    lo_val  = 8'd42;
    reset_p = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk);
      @(negedge clk);
      check4("rst_scan_com", com_n, (k < 4) ? 4'b1111 : ~(one4 << (((k - 4) / 4) % 4)));
      if (k < 4)                   check8("rst_seg_blank", seg_n, 8'hFF);
      else if (k <= 7)             check8("rst_seg_zero", seg_n, 8'hC0);
      else if (k >= 16 && k <= 19) check8("rst_seg_d3", seg_n, 8'hF8);
      else if (k >= 20)            check8("rst_seg_d0", seg_n, 8'hA4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
